pr_bridge: RTL

PR_BRIDGE -- requirements
Module: pr_bridge

---
 rtl/pr_bridge_pkg.sv | 39 +++
 rtl/pr_irq_sync.sv | 51 +++++
 rtl/pr_bridge.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/pr_bridge_pkg.sv
// Shared definitions for the processor/peripheral bridge: FSM encoding, address map, device count.
package pr_bridge_pkg;

  localparam int unsigned NUM_DEV = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    SEL_DEV0 = 3'd0,
    SEL_DEV1 = 3'd1,
    SEL_DEV2 = 3'd2,
    SEL_ACK  = 3'd3,
    SEL_NONE = 3'd4
  } dev_sel_t;

  localparam logic [31:0] DEV0_BASE  = 32'h0000_7F00;
  localparam logic [31:0] DEV0_LIMIT = 32'h0000_7F0B;
  localparam logic [31:0] DEV1_BASE  = 32'h0000_7F10;
  localparam logic [31:0] DEV1_LIMIT = 32'h0000_7F1B;
  localparam logic [31:0] DEV2_BASE  = 32'h0000_7F20;
  localparam logic [31:0] DEV2_LIMIT = 32'h0000_7F2F;
  localparam logic [31:0] ACK_ADDR   = 32'h0000_7F30;
  localparam logic [31:0] ACK_LIMIT  = 32'h0000_7F33;

  // Limits are the last byte of the last word, so byte offsets within a mapped word decode alike.
  function automatic dev_sel_t decode_addr(input logic [31:0] addr, input logic ack_en);
    if (addr >= DEV0_BASE && addr <= DEV0_LIMIT) return SEL_DEV0;
    if (addr >= DEV1_BASE && addr <= DEV1_LIMIT) return SEL_DEV1;
    if (addr >= DEV2_BASE && addr <= DEV2_LIMIT) return SEL_DEV2;
    if (ack_en && addr >= ACK_ADDR && addr <= ACK_LIMIT) return SEL_ACK;
    return SEL_NONE;
  endfunction

endpackage

// File: rtl/pr_irq_sync.sv
// Two-flop synchronizer for device interrupt levels, plus sticky rising-edge pending bits
// when PR_BRIDGE_IRQ_LATCH_EN is defined (otherwise the synchronized levels pass through).
module pr_irq_sync
  import pr_bridge_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_DEV-1:0] irq_i,
  input  logic [NUM_DEV-1:0] clr_i,
  output logic [NUM_DEV-1:0] irq_o
);

  logic [NUM_DEV-1:0] meta_q;
  logic [NUM_DEV-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= irq_i;
      sync_q <= meta_q;
    end
  end

`ifdef PR_BRIDGE_IRQ_LATCH_EN
  logic [NUM_DEV-1:0] prev_q;
  logic [NUM_DEV-1:0] pend_q;
  logic [NUM_DEV-1:0] pend_d;

  // A new edge overrides a clear landing in the same cycle.
  always_comb pend_d = (pend_q & ~clr_i) | (sync_q & ~prev_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= '0;
      pend_q <= '0;
    end else begin
      prev_q <= sync_q;
      pend_q <= pend_d;
    end
  end

  assign irq_o = pend_q;
`else
  logic [NUM_DEV-1:0] unused_clr;
  assign unused_clr = clr_i;
  assign irq_o      = sync_q;
`endif

endmodule

// File: rtl/pr_bridge.sv
// CPU-to-peripheral bridge: one access at a time, PrRdy pulses 2 cycles (writes/unmapped)
// or 2+WAIT_RD cycles (reads) after PrReq. Optional IRQ latching via PR_BRIDGE_IRQ_LATCH_EN.
module pr_bridge
  import pr_bridge_pkg::*;
#(
  parameter int unsigned WAIT_RD = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PrReq,
  input  logic [31:0] PrAddr,
  input  logic [31:0] PrWD,
  input  logic        Wen,
  output logic [31:0] PrRD,
  output logic        PrRdy,
  output logic        PrErr,
  output logic [3:0]  dev_addr,
  output logic [31:0] dev_wd,
  output logic [2:0]  dev_we,
  input  logic [31:0] dev_rd0,
  input  logic [31:0] dev_rd1,
  input  logic [31:0] dev_rd2,
  input  logic [2:0]  dev_irq,
  output logic [5:0]  HWInt
);

`ifdef PR_BRIDGE_IRQ_LATCH_EN
  localparam logic ACK_EN = 1'b1;
`else
  localparam logic ACK_EN = 1'b0;
`endif

  state_t             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wd_q, wd_d;
  logic               wen_q, wen_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [31:0]        rd_q, rd_d;
  logic               err_q, err_d;
  dev_sel_t           sel;
  logic [31:0]        rd_mux;
  logic [NUM_DEV-1:0] ack_clr;
  logic [NUM_DEV-1:0] irq_vec;

  assign sel = decode_addr(addr_q, ACK_EN);

  always_comb begin
    case (sel)
      SEL_DEV0: rd_mux = dev_rd0;
      SEL_DEV1: rd_mux = dev_rd1;
      SEL_DEV2: rd_mux = dev_rd2;
      SEL_ACK:  rd_mux = {29'b0, irq_vec};
      default:  rd_mux = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    wen_d   = wen_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    err_d   = err_q;
    dev_we  = '0;
    ack_clr = '0;
    case (state_q)
      ST_IDLE: begin
        if (PrReq) begin
          addr_d  = PrAddr;
          wd_d    = PrWD;
          wen_d   = Wen;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (sel == SEL_NONE) begin
          rd_d    = '0;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (wen_q) begin
          case (sel)
            SEL_DEV0: dev_we = 3'b001;
            SEL_DEV1: dev_we = 3'b010;
            SEL_DEV2: dev_we = 3'b100;
            default:  ack_clr = wd_q[NUM_DEV-1:0];
          endcase
          err_d   = 1'b0;
          state_d = ST_DONE;
        end else if (WAIT_RD == 0) begin
          rd_d    = rd_mux;
          err_d   = 1'b0;
          state_d = ST_DONE;
        end else begin
          cnt_d   = 2'(WAIT_RD - 1);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 2'd0) begin
          rd_d    = rd_mux;
          err_d   = 1'b0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wd_q    <= '0;
      wen_q   <= 1'b0;
      cnt_q   <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      wen_q   <= wen_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
    end
  end

  pr_irq_sync u_irq (
    .clk   (clk),
    .rst   (rst),
    .irq_i (dev_irq),
    .clr_i (ack_clr),
    .irq_o (irq_vec)
  );

  assign PrRdy    = (state_q == ST_DONE);
  assign PrRD     = rd_q;
  assign PrErr    = err_q;
  assign dev_addr = addr_q[3:0];
  assign dev_wd   = wd_q;
  assign HWInt    = {3'b000, irq_vec};

endmodule
